// File: rtl/seq_divider_16by8_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
package seq_divider_16by8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wide enough for any supported WIDTH; users slice off the low WIDTH bits.
  localparam logic [63:0] QUOT_ONES = '1;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_16by8_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract D.
module seq_divider_16by8_div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  output logic [W-1:0] r_next,
  output logic [W-1:0] q_next
);

  logic [W:0]   t;
  logic [W:0]   b;
  logic [W:0]   g;
  logic [W:0]   p;
  logic [W+1:0] borrow;
  logic [W-1:0] diff;

  assign t = {r, q[W-1]};
  assign b = {1'b0, d};
  // Borrow generated where t=0,b=1; passed through where the bits are equal.
  assign g = ~t & b;
  assign p = ~(t ^ b);

  always_comb begin
    borrow    = '0;
    borrow[0] = 1'b0;
    for (int i = 0; i <= W; i++) begin
      borrow[i+1] = g[i] | (p[i] & borrow[i]);
    end
  end

  // R < D keeps the top bit of a successful difference at zero.
  assign diff   = t[W-1:0] ^ b[W-1:0] ^ borrow[W-1:0];
  assign r_next = borrow[W+1] ? t[W-1:0] : diff;
  assign q_next = {q[W-2:0], ~borrow[W+1]};

endmodule

// File: rtl/seq_divider_16by8.sv
// Sequential radix-2 restoring divider, 2W-bit dividend by W-bit divisor.
// state | meaning
// IDLE  | ready for operands
// CALC  | one quotient bit per cycle, W cycles
// DONE  | result held until out_ready
module seq_divider_16by8
  import seq_divider_16by8_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic               overflow
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    count;

  seq_divider_16by8_div_step #(.W(WIDTH)) u_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (d_reg),
    .r_next (r_nxt),
    .q_next (q_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_reg    <= divisor;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              quotient  <= QUOT_ONES[WIDTH-1:0];
              remainder <= '0;
              div_zero  <= 1'b1;
              overflow  <= 1'b0;
            end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
              state     <= DONE;
              out_valid <= 1'b1;
              quotient  <= QUOT_ONES[WIDTH-1:0];
              remainder <= '0;
              div_zero  <= 1'b0;
              overflow  <= 1'b1;
            end else begin
              state <= CALC;
              r_reg <= dividend[2*WIDTH-1:WIDTH];
              q_reg <= dividend[WIDTH-1:0];
              count <= '0;
            end
          end
        end
        CALC: begin
          r_reg <= r_nxt;
          q_reg <= q_nxt;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= q_nxt;
            remainder <= r_nxt;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Directed-vector and randomized checks for seq_divider_16by8.
module tb_seq_divider_16by8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        overflow;

  int n_vec  = 0;
  int n_miss = 0;

  seq_divider_16by8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Presents operands, waits for the accept edge and then for out_valid.
  // Leaves the DUT in DONE, sampled 1 time unit after the edge that set out_valid.
  task automatic do_op(input logic [15:0] dd, input logic [7:0] dv,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic dz, output logic ov,
                       output int lat, output bit to);
    int guard;
    to = 1'b0;
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) to = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) to = 1'b1;
    q  = quotient;
    r  = remainder;
    dz = div_zero;
    ov = overflow;
  endtask

  initial begin
    logic [7:0] q, r, q0, r0;
    logic       dz, ov;
    int         lat;
    bit         to;
    bit         bad;
    int         guard;
    logic [15:0] dd;
    logic [7:0]  dv;

    vecs[0]  = '{16'h03E8, 8'h07, 8'd142, 8'd6,   1'b0, 1'b0, 9};
    vecs[1]  = '{16'hFEFF, 8'hFF, 8'd255, 8'd254, 1'b0, 1'b0, 9};
    vecs[2]  = '{16'h1234, 8'h00, 8'hFF,  8'd0,   1'b1, 1'b0, 1};
    vecs[3]  = '{16'h0800, 8'h08, 8'hFF,  8'd0,   1'b0, 1'b1, 1};
    vecs[4]  = '{16'hFE01, 8'hFF, 8'd255, 8'd0,   1'b0, 1'b0, 9};
    vecs[5]  = '{16'h0000, 8'h01, 8'd0,   8'd0,   1'b0, 1'b0, 9};
    vecs[6]  = '{16'h00FF, 8'h01, 8'd255, 8'd0,   1'b0, 1'b0, 9};
    vecs[7]  = '{16'h0100, 8'h01, 8'hFF,  8'd0,   1'b0, 1'b1, 1};
    vecs[8]  = '{16'h0000, 8'h00, 8'hFF,  8'd0,   1'b1, 1'b0, 1};
    vecs[9]  = '{16'hFFFF, 8'hFF, 8'hFF,  8'd0,   1'b0, 1'b1, 1};
    vecs[10] = '{16'h7530, 8'h96, 8'd200, 8'd0,   1'b0, 1'b0, 9};
    vecs[11] = '{16'h7530, 8'hC8, 8'd150, 8'd0,   1'b0, 1'b0, 9};
    vecs[12] = '{16'h00FF, 8'h10, 8'd15,  8'd15,  1'b0, 1'b0, 9};

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset quotient", int'(quotient), 0);
    check("reset remainder", int'(remainder), 0);
    check("reset flags", int'({div_zero, overflow}), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, consumer always ready.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      do_op(vecs[i].dd, vecs[i].dv, q, r, dz, ov, lat, to);
      check($sformatf("vec%0d timeout", i), int'(to), 0);
      check($sformatf("vec%0d quotient", i), int'(q), int'(vecs[i].q));
      check($sformatf("vec%0d remainder", i), int'(r), int'(vecs[i].r));
      check($sformatf("vec%0d div_zero", i), int'(dz), int'(vecs[i].dz));
      check($sformatf("vec%0d overflow", i), int'(ov), int'(vecs[i].ov));
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d back to idle", i), int'({in_ready, out_valid}), 2);
    end

    // Backpressure: result must hold, new operands must be ignored.
    out_ready = 1'b0;
    do_op(16'h03E8, 8'h07, q, r, dz, ov, lat, to);
    check("bp quotient", int'(q), 142);
    check("bp remainder", int'(r), 6);
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 16'h0010;
      divisor  = 8'h03;
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || quotient != 8'd142 || remainder != 8'd6 ||
          div_zero || overflow) bad = 1'b1;
    end
    check("bp hold stable", int'(bad), 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp release to idle", int'({in_ready, out_valid}), 2);
    check("bp no accept in done", int'(quotient), 142);

    // Reset on the 4th CALC cycle discards the operation.
    @(negedge clk);
    dividend = 16'h03E8;
    divisor  = 8'h07;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midcalc rst ready/valid", int'({in_ready, out_valid}), 2);
    check("midcalc rst quotient", int'(quotient), 0);
    check("midcalc rst remainder", int'(remainder), 0);
    check("midcalc rst flags", int'({div_zero, overflow}), 0);
    bad = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) bad = 1'b1;
    end
    check("midcalc no stale result", int'(bad), 0);
    do_op(16'hFE01, 8'hFF, q, r, dz, ov, lat, to);
    check("post rst quotient", int'(q), 255);
    check("post rst remainder", int'(r), 0);
    check("post rst latency", lat, 9);
    @(posedge clk);
    #1;

    // Random operands with random consumer backpressure.
    for (int n = 0; n < 2000; n++) begin
      dd = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       dv = 8'h00;
        1:       dv = 8'hFF;
        2:       dd = {8'($urandom_range(0, 15)), 8'($urandom)};
        default: dv = 8'($urandom);
      endcase
      if (dv == 8'h00 && $urandom_range(0, 3) != 0) dv = 8'($urandom_range(1, 255));
      out_ready = 1'b0;
      do_op(dd, dv, q, r, dz, ov, lat, to);
      bad = to;
      if (dv == 8'h00) begin
        if (!(dz && !ov && q == 8'hFF && r == 8'h00 && lat == 1)) bad = 1'b1;
      end else if (dd[15:8] >= dv) begin
        if (!(!dz && ov && q == 8'hFF && r == 8'h00 && lat == 1)) bad = 1'b1;
      end else begin
        if (dz || ov || lat != 9 || r >= dv ||
            (32'(q) * 32'(dv) + 32'(r)) != 32'(dd)) bad = 1'b1;
      end
      q0 = q;
      r0 = r;
      guard = 0;
      while (out_valid && guard < 40) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        if (out_valid && (quotient != q0 || remainder != r0 || in_ready)) bad = 1'b1;
        guard++;
      end
      if (out_valid) bad = 1'b1;
      if (bad) $display("FAIL rand op %0d: %0d/%0d got q=%0d r=%0d dz=%0d ov=%0d lat=%0d",
                        n, dd, dv, q, r, dz, ov, lat);
      check("rand op", int'(bad), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
